seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 8, SHALL set the operand and result width; legal values are powers of two, 4 to 64.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 START  input  1  SHALL request a new operation.
REQ-005 OPCODE  input  3  SHALL select the operation: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 LSL, 110 LSR, 111 ROR.
REQ-006 DATA1  input  W  SHALL be operand A.
REQ-007 DATA2  input  W  SHALL be operand B, which is also the shift amount.
REQ-008 BUSY  output  1  SHALL be high while an accepted operation is in flight.
REQ-009 DONE  output  1  SHALL be a one-cycle pulse marking a new valid RESULT.
REQ-010 RESULT  output  W  SHALL be the result of the last completed operation.
REQ-011 ZERO  output  1  SHALL be high when the last completed RESULT equals 0.
REQ-012 CARRY  output  1  SHALL be the carry-out of the last completed ADD, and 0 for every other opcode.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and MULT; the reset state is IDLE; BUSY = (state != IDLE).
REQ-014 An operation SHALL be accepted on an edge where START=1 and state=IDLE; DATA1, DATA2 and OPCODE are latched on that same edge.
REQ-015 START SHALL be ignored while BUSY=1; later changes on DATA1, DATA2 or OPCODE SHALL NOT affect an operation in flight.
REQ-016 Non-MUL opcodes accepted at edge k: state IDLE->EXEC; at edge k+1 state EXEC->IDLE, and RESULT, ZERO, CARRY update with DONE=1 for that one cycle.
REQ-017 MUL accepted at edge k: state IDLE->MULT; shift-add iteration runs one bit of B per cycle for W cycles; at edge k+W RESULT = low W bits of A*B, DONE=1, state->IDLE.
REQ-018 FWD SHALL give RESULT=B; AND and OR SHALL be bitwise; ADD SHALL give RESULT=(A+B) mod 2^W with CARRY = bit W of the sum.
REQ-019 LSL and LSR SHALL shift logically by B (zero fill); if B >= W then RESULT=0.
REQ-020 ROR SHALL rotate A right by B mod W.
REQ-021 RESULT, ZERO and CARRY SHALL hold their values between DONE pulses.
REQ-022 A START asserted during the DONE cycle SHALL be accepted on the next edge, giving peak throughput of one single-cycle op per 2 cycles.
REQ-023 MUL overflow SHALL be discarded silently; CARRY=0 for MUL.

Reset
REQ-024 While RESET=1 at an edge, state SHALL go to IDLE and BUSY, DONE, RESULT, ZERO and CARRY SHALL all be 0; RESET has priority over START.
REQ-025 A RESET during EXEC or MULT SHALL abandon the operation with no DONE pulse; the first START after RESET falls SHALL be accepted normally.

Verification (W=8)
REQ-026 ADD A=200, B=100 -> one edge after accept: RESULT=44, CARRY=1, ZERO=0, DONE high exactly 1 cycle.
REQ-027 MUL 13*11 -> RESULT=143 with DONE exactly 8 edges after accept; MUL 16*16 -> RESULT=0, ZERO=1, CARRY=0.
REQ-028 Shifts -> LSL 0x81 by 1 = 0x02; LSR 0xFF by 9 = 0x00 with ZERO=1; ROR 0x01 by 9 = 0x80.
REQ-029 START pulsed with new operands mid-MUL -> ignored; MUL result is unaffected and no extra DONE occurs; START held high through DONE -> second op accepted on the next edge.
REQ-030 RESET at the 4th MUL cycle -> all outputs 0 on the next edge and no DONE; a subsequent OR 0xF0|0x0F -> RESULT=0xFF.

Source files
------------

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : sequential ALU with a one-cycle execute path for simple opcodes
//           and a W-cycle shift-add multiplier.
//
// Parameters
//   W       operand/result width (power of two, 4..64)
//
// Ports
//   CLK     input   clock, all state updates on the rising edge
//   RESET   input   synchronous active-high reset
//   START   input   request a new operation (taken only when idle)
//   OPCODE  input   3-bit operation select
//                   000 FWD, 001 ADD, 010 AND, 011 OR,
//                   100 MUL, 101 LSL, 110 LSR, 111 ROR
//   DATA1   input   operand A
//   DATA2   input   operand B / shift amount
//   BUSY    output  high while an accepted operation is in flight
//   DONE    output  one-cycle pulse marking a new RESULT
//   RESULT  output  result of the last completed operation
//   ZERO    output  RESULT == 0 for the last completed operation
//   CARRY   output  carry-out of the last completed ADD, else 0
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [2:0]   OPCODE,
    input  logic [W-1:0] DATA1,
    input  logic [W-1:0] DATA2,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] RESULT,
    output logic         ZERO,
    output logic         CARRY
);

    localparam int SW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MULT = 2'd2;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);

    logic [1:0]    state_q,  state_d;
    logic [2:0]    op_q,     op_d;
    logic [W-1:0]  a_q,      a_d;
    logic [W-1:0]  b_q,      b_d;
    logic [W-1:0]  acc_q,    acc_d;
    logic [SW-1:0] cnt_q,    cnt_d;
    logic [W-1:0]  result_q, result_d;
    logic          zero_q,   zero_d;
    logic          carry_q,  carry_d;
    logic          done_q,   done_d;

    // Single-cycle ALU, fed only from the operands latched at accept time.
    logic [W-1:0]   alu_res;
    logic           alu_carry;
    logic [W:0]     sum;
    logic [2*W-1:0] rot;
    logic [SW-1:0]  shift_amt;
    logic           shift_big;
    logic [W-1:0]   mul_acc_next;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        shift_amt = b_q[SW-1:0];
        // W is a power of two, so B >= W exactly when any bit above
        // the low SW bits is set.
        shift_big = |(b_q >> SW);
        sum       = {1'b0, a_q} + {1'b0, b_q};
        // Rotating right is the low half of {A,A} shifted right.
        rot       = {a_q, a_q} >> shift_amt;
        case (op_q)
            OP_FWD: alu_res = b_q;
            OP_ADD: begin
                alu_res   = sum[W-1:0];
                alu_carry = sum[W];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_LSL: alu_res = shift_big ? '0 : (a_q << shift_amt);
            OP_LSR: alu_res = shift_big ? '0 : (a_q >> shift_amt);
            OP_ROR: alu_res = rot[W-1:0];
            default: alu_res = '0;  // MUL never reaches the execute path
        endcase
    end

    // Shift-add step: a_q holds A shifted left by the iteration count,
    // b_q holds B shifted right, so b_q[0] is the current multiplier bit.
    assign mul_acc_next = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d    = OPCODE;
                    a_d     = DATA1;
                    b_d     = DATA2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (OPCODE == OP_MUL) ? S_MULT : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                carry_d  = alu_carry;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            S_MULT: begin
                acc_d = mul_acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Bits above W are simply never formed: overflow drops.
                    result_d = mul_acc_next;
                    zero_d   = (mul_acc_next == '0);
                    carry_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign ZERO   = zero_q;
    assign CARRY  = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu : self-checking bench for seq_alu at W=8. Directed cases plus
// randomized operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         RESET;
    logic         START;
    logic [2:0]   OPCODE;
    logic [W-1:0] DATA1;
    logic [W-1:0] DATA2;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         ZERO;
    logic         CARRY;

    int total = 0;
    int bad   = 0;

    seq_alu #(.W(W)) dut (
        .CLK    (clk),
        .RESET  (RESET),
        .START  (START),
        .OPCODE (OPCODE),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .ZERO   (ZERO),
        .CARRY  (CARRY)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic void ref_op(input logic [2:0] op, input int a, input int b,
                                   output int r, output bit c);
        int s;
        c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b001: begin s = a + b; r = s % 256; c = (s >= 256); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = (a * b) % 256;
            3'b101: r = (b >= W) ? 0 : ((a << b) % 256);
            3'b110: r = (b >= W) ? 0 : (a >> b);
            default: begin s = b % W; r = ((a >> s) | (a << (W - s))) % 256; end
        endcase
    endfunction

    // Issues one operation from an idle DUT, scrambles the inputs right after
    // acceptance, and waits (bounded) for DONE. lat = -1 on timeout.
    task automatic do_op(input logic [2:0] op, input int a, input int b,
                         output int lat, output logic busy_after);
        START  = 1'b1;
        OPCODE = op;
        DATA1  = W'(a);
        DATA2  = W'(b);
        @(posedge clk); #1;
        busy_after = BUSY;
        START  = 1'b0;
        OPCODE = 3'($urandom);
        DATA1  = W'($urandom);
        DATA2  = W'($urandom);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (DONE) begin
                lat = i;
                break;
            end
        end
        $display("op=%0d a=%0d b=%0d -> result=%0d zero=%0d carry=%0d lat=%0d",
                 op, a, b, RESULT, ZERO, CARRY, lat);
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b1; OPCODE = 3'b001; DATA1 = 8'd5; DATA2 = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({BUSY, DONE, RESULT, ZERO, CARRY} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%0d done=%0d result=%0d zero=%0d carry=%0d want all 0",
                     BUSY, DONE, RESULT, ZERO, CARRY);
        end
        RESET = 1'b0; START = 1'b0;
        @(posedge clk); #1;
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy got=%0d want=0", BUSY);
        end
    endtask

    task automatic test_directed();
        int lat;
        logic bz;
        logic [W-1:0] held;
        // ADD with carry
        do_op(3'b001, 200, 100, lat, bz);
        total++;
        if (bz !== 1'b1) begin bad++; $display("FAIL add_busy got=%0d want=1", bz); end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        total++;
        if ({RESULT, CARRY, ZERO} !== {8'd44, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL add_value got result=%0d carry=%0d zero=%0d want 44/1/0", RESULT, CARRY, ZERO);
        end
        held = RESULT;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (DONE !== 1'b0 || RESULT !== held || CARRY !== 1'b1 || BUSY !== 1'b0) begin
                bad++;
                $display("FAIL add_hold got done=%0d result=%0d carry=%0d busy=%0d want 0/%0d/1/0",
                         DONE, RESULT, CARRY, BUSY, held);
            end
        end
        // MUL 13*11
        do_op(3'b100, 13, 11, lat, bz);
        total++;
        if (lat !== 8 || RESULT !== 8'd143) begin
            bad++;
            $display("FAIL mul_13x11 got lat=%0d result=%0d want 8/143", lat, RESULT);
        end
        // MUL overflow to zero
        do_op(3'b100, 16, 16, lat, bz);
        total++;
        if (lat !== 8 || RESULT !== 8'd0 || ZERO !== 1'b1 || CARRY !== 1'b0) begin
            bad++;
            $display("FAIL mul_16x16 got lat=%0d result=%0d zero=%0d carry=%0d want 8/0/1/0",
                     lat, RESULT, ZERO, CARRY);
        end
        // Shifts
        do_op(3'b101, 8'h81, 1, lat, bz);
        total++;
        if (lat !== 1 || RESULT !== 8'h02) begin
            bad++;
            $display("FAIL lsl got lat=%0d result=%h want 1/02", lat, RESULT);
        end
        do_op(3'b110, 8'hFF, 9, lat, bz);
        total++;
        if (RESULT !== 8'h00 || ZERO !== 1'b1) begin
            bad++;
            $display("FAIL lsr_big got result=%h zero=%0d want 00/1", RESULT, ZERO);
        end
        do_op(3'b111, 8'h01, 9, lat, bz);
        total++;
        if (RESULT !== 8'h80 || ZERO !== 1'b0) begin
            bad++;
            $display("FAIL ror got result=%h zero=%0d want 80/0", RESULT, ZERO);
        end
    endtask

    task automatic test_random();
        int lat, a, b, r;
        bit c;
        logic bz;
        logic [2:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom);
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
            ref_op(op, a, b, r, c);
            do_op(op, a, b, lat, bz);
            total++;
            if (lat !== ((op == 3'b100) ? 8 : 1) || bz !== 1'b1) begin
                bad++;
                $display("FAIL rand_timing op=%0d got lat=%0d busy=%0d want lat=%0d busy=1",
                         op, lat, bz, (op == 3'b100) ? 8 : 1);
            end
            total++;
            if (RESULT !== W'(r) || ZERO !== (r == 0) || CARRY !== c) begin
                bad++;
                $display("FAIL rand_value op=%0d a=%0d b=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         op, a, b, RESULT, ZERO, CARRY, r, (r == 0), c);
            end
            @(posedge clk); #1;
            total++;
            if (DONE !== 1'b0) begin
                bad++;
                $display("FAIL rand_done_width got done=%0d want=0", DONE);
            end
        end
    endtask

    task automatic test_mul_ignore_start();
        int dones = 0, first = -1, a, b, r;
        bit c;
        logic [W-1:0] res_at_done = '0;
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        ref_op(3'b100, a, b, r, c);
        START = 1'b1; OPCODE = 3'b100; DATA1 = W'(a); DATA2 = W'(b);
        @(posedge clk); #1;
        START = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            if (DONE) begin
                dones++;
                if (first < 0) begin first = cyc; res_at_done = RESULT; end
            end
            if (cyc == 3) begin
                START = 1'b1; OPCODE = 3'b001; DATA1 = W'($urandom); DATA2 = W'($urandom);
            end
            if (cyc == 4) START = 1'b0;
        end
        $display("mul_ignore a=%0d b=%0d result=%0d dones=%0d first=%0d", a, b, res_at_done, dones, first);
        total++;
        if (dones !== 1 || first !== 8) begin
            bad++;
            $display("FAIL mul_ignore_timing got dones=%0d first=%0d want 1/8", dones, first);
        end
        total++;
        if (res_at_done !== W'(r)) begin
            bad++;
            $display("FAIL mul_ignore_value got=%0d want=%0d", res_at_done, r);
        end
    endtask

    task automatic test_back_to_back();
        int r1, r2, a1, b1, a2, b2;
        bit c1, c2;
        a1 = int'($urandom_range(0, 255)); b1 = int'($urandom_range(0, 255));
        a2 = int'($urandom_range(0, 255)); b2 = int'($urandom_range(0, 255));
        ref_op(3'b001, a1, b1, r1, c1);
        ref_op(3'b010, a2, b2, r2, c2);
        START = 1'b1; OPCODE = 3'b001; DATA1 = W'(a1); DATA2 = W'(b1);
        @(posedge clk); #1;                       // accept op 1
        @(posedge clk); #1;                       // op 1 done, START still high
        total++;
        if (DONE !== 1'b1 || RESULT !== W'(r1) || CARRY !== c1) begin
            bad++;
            $display("FAIL b2b_first got done=%0d result=%0d carry=%0d want 1/%0d/%0d", DONE, RESULT, CARRY, r1, c1);
        end
        OPCODE = 3'b010; DATA1 = W'(a2); DATA2 = W'(b2);
        @(posedge clk); #1;                       // op 2 accepted here
        total++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept got busy=%0d done=%0d want 1/0", BUSY, DONE);
        end
        START = 1'b0;
        @(posedge clk); #1;
        total++;
        if (DONE !== 1'b1 || RESULT !== W'(r2) || CARRY !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second got done=%0d result=%0d carry=%0d want 1/%0d/0", DONE, RESULT, CARRY, r2);
        end
        $display("b2b add %0d+%0d=%0d then and %0d&%0d=%0d", a1, b1, r1, a2, b2, RESULT);
    endtask

    task automatic test_reset_mid_mul();
        int lat, dones = 0;
        logic bz;
        do_op(3'b001, 1, 1, lat, bz);             // leave a nonzero RESULT behind
        START = 1'b1; OPCODE = 3'b100; DATA1 = 8'd13; DATA2 = 8'd11;
        @(posedge clk); #1;
        START = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        RESET = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({BUSY, DONE, RESULT, ZERO, CARRY} !== '0) begin
            bad++;
            $display("FAIL reset_mid_mul got busy=%0d done=%0d result=%0d zero=%0d carry=%0d want all 0",
                     BUSY, DONE, RESULT, ZERO, CARRY);
        end
        RESET = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (DONE) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_no_done got=%0d want=0", dones);
        end
        do_op(3'b011, 8'hF0, 8'h0F, lat, bz);
        total++;
        if (lat !== 1 || RESULT !== 8'hFF || ZERO !== 1'b0) begin
            bad++;
            $display("FAIL or_after_reset got lat=%0d result=%h zero=%0d want 1/ff/0", lat, RESULT, ZERO);
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; OPCODE = '0; DATA1 = '0; DATA2 = '0;
        test_reset();
        test_directed();
        test_random();
        test_mul_ignore_start();
        test_back_to_back();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
